// File: rtl/gray_rx_decoder_if.sv
// ---------------------------------------------------------------------------
// gray_rx_decoder_if
//   Bundles the sample/control inputs and the status outputs of the Gray
//   stream decoder.
//   master : the side that supplies Valid/Gray/Clr and observes the status.
//   slave  : the decoder itself.
//   Signals:
//     Valid      - Gray sample qualifier
//     Gray       - Gray-coded input word (W bits)
//     Clr        - synchronous clear of state, counter and sticky error
//     Bin        - registered binary decode of last accepted sample
//     Bin_valid  - one-cycle pulse, Bin updated
//     Overflow   - one-cycle pulse, accepted step 2^W-1 -> 0
//     Step_err   - one-cycle pulse, illegal transition
//     Err_sticky - latched error flag
//     Wrap_cnt   - saturating count of Overflow events
//     State      - 00 IDLE, 01 LOCK, 10 ERR
// ---------------------------------------------------------------------------
interface gray_rx_decoder_if #(
  parameter int W          = 3,
  parameter int WRAP_CNT_W = 8
);
  logic                  Valid;
  logic [W-1:0]          Gray;
  logic                  Clr;
  logic [W-1:0]          Bin;
  logic                  Bin_valid;
  logic                  Overflow;
  logic                  Step_err;
  logic                  Err_sticky;
  logic [WRAP_CNT_W-1:0] Wrap_cnt;
  logic [1:0]            State;

  modport master (
    output Valid, Gray, Clr,
    input  Bin, Bin_valid, Overflow, Step_err, Err_sticky, Wrap_cnt, State
  );

  modport slave (
    input  Valid, Gray, Clr,
    output Bin, Bin_valid, Overflow, Step_err, Err_sticky, Wrap_cnt, State
  );
endinterface

// File: rtl/gray_rx_decoder.sv
// ---------------------------------------------------------------------------
// gray_rx_decoder
//   Receives a Gray-coded counter word, decodes it to binary and checks that
//   the stream only holds or advances by +1 (modulo 2^W). Reports the decoded
//   value, wrap events, illegal steps, a sticky error flag and a saturating
//   wrap count. All outputs are registered; one cycle of latency.
//
//   Ports:
//     Clk     - system clock, rising edge
//     Reset_n - asynchronous active-low reset (all outputs to 0, State IDLE)
//     bus     - gray_rx_decoder_if.slave (Valid, Gray, Clr in;
//               Bin, Bin_valid, Overflow, Step_err, Err_sticky, Wrap_cnt,
//               State out)
//
//   Optional feature macro: GRAY_DEC_ZERO_RESYNC_EN
//     When defined, a jump to 0 while locked (from a value other than 0 or
//     2^W-1) is accepted as an upstream counter reset instead of an error.
// ---------------------------------------------------------------------------
module gray_rx_decoder #(
  parameter int W          = 3,
  parameter int WRAP_CNT_W = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  gray_rx_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOCK = 2'b01,
    ERR  = 2'b10
  } state_t;

  localparam logic [W-1:0]          BIN_MAX  = {W{1'b1}};
  localparam logic [W-1:0]          STEP_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_CNT_W-1:0] WRAP_MAX = {WRAP_CNT_W{1'b1}};

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WRAP_CNT_W-1:0] sat_inc(input logic [WRAP_CNT_W-1:0] c);
    return (c == WRAP_MAX) ? c : c + 1'b1;
  endfunction

  state_t                state;
  logic [W-1:0]          bin_p1;
  logic                  vld_p1;
  logic                  ovf_p1;
  logic                  err_p1;
  logic                  sticky;
  logic [WRAP_CNT_W-1:0] wrap_cnt;

  logic [W-1:0]          bin_p0;
  logic [W-1:0]          step_p0;

  // Stage p0: combinational decode of the incoming sample and its distance
  // from the previously accepted value (modulo 2^W).
  assign bin_p0  = gray2bin(bus.Gray);
  assign step_p0 = bin_p0 - bin_p1;

  // Stage p1: registered result and stream-tracking FSM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      bin_p1   <= '0;
      vld_p1   <= 1'b0;
      ovf_p1   <= 1'b0;
      err_p1   <= 1'b0;
      sticky   <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      vld_p1 <= 1'b0;
      ovf_p1 <= 1'b0;
      err_p1 <= 1'b0;
      if (bus.Clr) begin
        // The sample on this edge is dropped; Bin keeps the last value.
        state    <= IDLE;
        sticky   <= 1'b0;
        wrap_cnt <= '0;
      end else if (bus.Valid) begin
        bin_p1 <= bin_p0;
        vld_p1 <= 1'b1;
        case (state)
          LOCK: begin
            if (step_p0 == STEP_ONE) begin
              // A +1 step from the top value can only land on 0: a wrap.
              if (bin_p1 == BIN_MAX) begin
                ovf_p1   <= 1'b1;
                wrap_cnt <= sat_inc(wrap_cnt);
              end
            end else if (step_p0 != '0) begin
`ifdef GRAY_DEC_ZERO_RESYNC_EN
              // Landing on 0 here means prev was neither 0 nor max (those
              // are the hold and wrap cases), so treat it as a resync.
              if (bin_p0 != '0) begin
                err_p1 <= 1'b1;
                sticky <= 1'b1;
                state  <= ERR;
              end
`else
              err_p1 <= 1'b1;
              sticky <= 1'b1;
              state  <= ERR;
`endif
            end
          end
          // IDLE and ERR: this sample becomes the new reference.
          default: state <= LOCK;
        endcase
      end
    end
  end

  assign bus.Bin        = bin_p1;
  assign bus.Bin_valid  = vld_p1;
  assign bus.Overflow   = ovf_p1;
  assign bus.Step_err   = err_p1;
  assign bus.Err_sticky = sticky;
  assign bus.Wrap_cnt   = wrap_cnt;
  assign bus.State      = state;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// ---------------------------------------------------------------------------
// tb_gray_rx_decoder
//   Directed bench for gray_rx_decoder. Two instances share clock, reset and
//   inputs: dut (WRAP_CNT_W=8) and dut_sat (WRAP_CNT_W=2, saturation checks).
//   Expectations for the zero-resync case follow GRAY_DEC_ZERO_RESYNC_EN.
// ---------------------------------------------------------------------------
module tb_gray_rx_decoder;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  gray_rx_decoder_if #(.W(3), .WRAP_CNT_W(8)) if1 ();
  gray_rx_decoder_if #(.W(3), .WRAP_CNT_W(2)) if2 ();

  assign if2.Valid = if1.Valid;
  assign if2.Gray  = if1.Gray;
  assign if2.Clr   = if1.Clr;

  gray_rx_decoder #(.W(3), .WRAP_CNT_W(8)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (if1.slave)
  );

  gray_rx_decoder #(.W(3), .WRAP_CNT_W(2)) dut_sat (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray code of binary 0..7
  logic [2:0] gtab [8];
  initial gtab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  // Drive one input set at the falling edge, return 1 time unit after the
  // following rising edge so registered outputs can be sampled.
  task automatic cyc(input logic v, input logic [2:0] g, input logic c);
    @(negedge clk);
    if1.Valid = v;
    if1.Gray  = g;
    if1.Clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    if1.Valid = 1'b0;
    if1.Gray  = 3'b000;
    if1.Clr   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    if1.Valid = 1'b1;
    if1.Gray  = 3'b101;
    if1.Clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if1.Bin !== 3'd0) begin errors++; $display("FAIL reset_bin got %0d exp 0", if1.Bin); end
    checks++; if ({if1.Bin_valid, if1.Overflow, if1.Step_err, if1.Err_sticky} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {if1.Bin_valid, if1.Overflow, if1.Step_err, if1.Err_sticky}); end
    checks++; if (if1.Wrap_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap got %0d exp 0", if1.Wrap_cnt); end
    checks++; if (if1.State !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", if1.State); end
    @(negedge clk);
    if1.Valid = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic test_count_wrap();
    logic [2:0] exp_bin;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, gtab[i % 8], 1'b0);
      exp_bin = 3'(i % 8);
      checks++; if (if1.Bin !== exp_bin || if1.Bin_valid !== 1'b1) begin
        errors++; $display("FAIL count_bin i=%0d got %0d/%b exp %0d/1", i, if1.Bin, if1.Bin_valid, exp_bin); end
      checks++; if (if1.Overflow !== (i == 8)) begin
        errors++; $display("FAIL count_ovf i=%0d got %b exp %b", i, if1.Overflow, (i == 8)); end
      checks++; if (if1.Step_err !== 1'b0) begin
        errors++; $display("FAIL count_err i=%0d got %b exp 0", i, if1.Step_err); end
    end
    cyc(1'b0, 3'b000, 1'b0);
    checks++; if (if1.Overflow !== 1'b0 || if1.Bin_valid !== 1'b0) begin
      errors++; $display("FAIL count_pulse_len got ovf=%b bv=%b exp 0/0", if1.Overflow, if1.Bin_valid); end
    checks++; if (if1.Wrap_cnt !== 8'd1) begin errors++; $display("FAIL count_wrap got %0d exp 1", if1.Wrap_cnt); end
    checks++; if (if1.State !== 2'b01) begin errors++; $display("FAIL count_state got %b exp 01", if1.State); end
  endtask

  task automatic test_hold();
    cyc(1'b1, 3'b001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc((i < 3), 3'b011, 1'b0);
      checks++; if (if1.Bin !== 3'd2) begin errors++; $display("FAIL hold_bin i=%0d got %0d exp 2", i, if1.Bin); end
      checks++; if (if1.Bin_valid !== (i < 3)) begin
        errors++; $display("FAIL hold_bv i=%0d got %b exp %b", i, if1.Bin_valid, (i < 3)); end
      checks++; if (if1.Step_err !== 1'b0) begin errors++; $display("FAIL hold_err i=%0d got %b exp 0", i, if1.Step_err); end
    end
  endtask

  task automatic test_step_err();
    // Walk 2 -> 3..7 -> 0 -> 1 legally (second wrap), then jump 1 -> 4.
    for (int i = 3; i < 10; i++) cyc(1'b1, gtab[i % 8], 1'b0);
    checks++; if (if1.Bin !== 3'd1 || if1.Wrap_cnt !== 8'd2) begin
      errors++; $display("FAIL err_pre got bin=%0d wrap=%0d exp 1/2", if1.Bin, if1.Wrap_cnt); end
    cyc(1'b1, 3'b110, 1'b0);
    checks++; if (if1.Step_err !== 1'b1 || if1.Err_sticky !== 1'b1 || if1.State !== 2'b10) begin
      errors++; $display("FAIL err_jump got err=%b sticky=%b st=%b exp 1/1/10", if1.Step_err, if1.Err_sticky, if1.State); end
    checks++; if (if1.Bin !== 3'd4 || if1.Overflow !== 1'b0 || if1.Wrap_cnt !== 8'd2) begin
      errors++; $display("FAIL err_jump_data got bin=%0d ovf=%b wrap=%0d exp 4/0/2", if1.Bin, if1.Overflow, if1.Wrap_cnt); end
    cyc(1'b1, 3'b111, 1'b0);
    checks++; if (if1.State !== 2'b01 || if1.Step_err !== 1'b0 || if1.Bin !== 3'd5) begin
      errors++; $display("FAIL err_reref got st=%b err=%b bin=%0d exp 01/0/5", if1.State, if1.Step_err, if1.Bin); end
    cyc(1'b1, 3'b101, 1'b0);
    checks++; if (if1.Step_err !== 1'b0 || if1.Err_sticky !== 1'b1 || if1.Bin !== 3'd6) begin
      errors++; $display("FAIL err_after got err=%b sticky=%b bin=%0d exp 0/1/6", if1.Step_err, if1.Err_sticky, if1.Bin); end
  endtask

  task automatic test_clear();
    cyc(1'b1, 3'b001, 1'b1);
    checks++; if (if1.Wrap_cnt !== 8'd0 || if1.Err_sticky !== 1'b0) begin
      errors++; $display("FAIL clr_cnt got wrap=%0d sticky=%b exp 0/0", if1.Wrap_cnt, if1.Err_sticky); end
    checks++; if (if1.Bin_valid !== 1'b0 || if1.State !== 2'b00 || if1.Bin !== 3'd6) begin
      errors++; $display("FAIL clr_state got bv=%b st=%b bin=%0d exp 0/00/6", if1.Bin_valid, if1.State, if1.Bin); end
    // First sample after clear is a fresh reference: 6 -> 1 is not an error.
    cyc(1'b1, 3'b001, 1'b0);
    checks++; if (if1.Bin !== 3'd1 || if1.State !== 2'b01 || if1.Step_err !== 1'b0) begin
      errors++; $display("FAIL clr_reload got bin=%0d st=%b err=%b exp 1/01/0", if1.Bin, if1.State, if1.Step_err); end
  endtask

  task automatic test_saturate();
    int ovf_seen;
    logic [1:0] exp_sat;
    ovf_seen = 0;
    do_reset();
    cyc(1'b1, 3'b000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      for (int j = 1; j <= 8; j++) begin
        cyc(1'b1, gtab[j % 8], 1'b0);
        if (if2.Overflow === 1'b1) ovf_seen++;
      end
      exp_sat = (k > 3) ? 2'd3 : 2'(k);
      checks++; if (if2.Overflow !== 1'b1 || if2.Wrap_cnt !== exp_sat) begin
        errors++; $display("FAIL sat_wrap k=%0d got ovf=%b cnt=%0d exp 1/%0d", k, if2.Overflow, if2.Wrap_cnt, exp_sat); end
      checks++; if (if1.Wrap_cnt !== 8'(k)) begin
        errors++; $display("FAIL wide_wrap k=%0d got %0d exp %0d", k, if1.Wrap_cnt, k); end
    end
    checks++; if (ovf_seen != 5) begin errors++; $display("FAIL sat_ovf_count got %0d exp 5", ovf_seen); end
  endtask

  task automatic test_zero_resync();
    do_reset();
    cyc(1'b1, 3'b101, 1'b0);
    checks++; if (if1.Bin !== 3'd6 || if1.State !== 2'b01) begin
      errors++; $display("FAIL zr_load got bin=%0d st=%b exp 6/01", if1.Bin, if1.State); end
    cyc(1'b1, 3'b000, 1'b0);
`ifdef GRAY_DEC_ZERO_RESYNC_EN
    checks++; if (if1.Bin !== 3'd0 || if1.Step_err !== 1'b0 || if1.State !== 2'b01 || if1.Err_sticky !== 1'b0) begin
      errors++; $display("FAIL zr_resync got bin=%0d err=%b st=%b sticky=%b exp 0/0/01/0",
                         if1.Bin, if1.Step_err, if1.State, if1.Err_sticky); end
`else
    checks++; if (if1.Bin !== 3'd0 || if1.Step_err !== 1'b1 || if1.State !== 2'b10 || if1.Err_sticky !== 1'b1) begin
      errors++; $display("FAIL zr_illegal got bin=%0d err=%b st=%b sticky=%b exp 0/1/10/1",
                         if1.Bin, if1.Step_err, if1.State, if1.Err_sticky); end
`endif
    checks++; if (if1.Overflow !== 1'b0 || if1.Wrap_cnt !== 8'd0 || if1.Bin_valid !== 1'b1) begin
      errors++; $display("FAIL zr_side got ovf=%b wrap=%0d bv=%b exp 0/0/1", if1.Overflow, if1.Wrap_cnt, if1.Bin_valid); end
    cyc(1'b1, 3'b001, 1'b0);
    checks++; if (if1.Bin !== 3'd1 || if1.State !== 2'b01 || if1.Bin_valid !== 1'b1) begin
      errors++; $display("FAIL zr_next got bin=%0d st=%b bv=%b exp 1/01/1", if1.Bin, if1.State, if1.Bin_valid); end
    // Asynchronous reset between edges: outputs clear before the next edge.
    @(negedge clk);
    if1.Gray = 3'b011;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if1.Bin !== 3'd0 || if1.Bin_valid !== 1'b0 || if1.State !== 2'b00) begin
      errors++; $display("FAIL async_rst got bin=%0d bv=%b st=%b exp 0/0/00", if1.Bin, if1.Bin_valid, if1.State); end
    checks++; if (if1.Err_sticky !== 1'b0 || if1.Wrap_cnt !== 8'd0 || if1.Step_err !== 1'b0 || if1.Overflow !== 1'b0) begin
      errors++; $display("FAIL async_rst_flags got sticky=%b wrap=%0d err=%b ovf=%b exp 0/0/0/0",
                         if1.Err_sticky, if1.Wrap_cnt, if1.Step_err, if1.Overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    // 0 -> 2 would be illegal if locked; after reset it is the first sample.
    cyc(1'b1, 3'b011, 1'b0);
    checks++; if (if1.Bin !== 3'd2 || if1.State !== 2'b01 || if1.Step_err !== 1'b0) begin
      errors++; $display("FAIL post_rst got bin=%0d st=%b err=%b exp 2/01/0", if1.Bin, if1.State, if1.Step_err); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_count_wrap();
    test_hold();
    test_step_err();
    test_clear();
    test_saturate();
    test_zero_resync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_rx_decoder.md
Name: gray_rx_decoder

Overview:
- Receiving end of the Gray-coded counter interface: samples a W-bit Gray word qualified by Valid, decodes it to binary and checks that the stream advances legally.
- Legal stream: hold, or +1 step with modulo wrap.
- Reports decoded value, wrap events and illegal steps, and keeps a saturating wrap count.
- Sits downstream of the Gray counter, e.g. as a clock-domain-safe position monitor or checker in the P1 datapath.

Parameters:
W, 3, Gray/binary word width (>=2)
WRAP_CNT_W, 8, width of saturating wrap counter

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Valid  input  1  Gray sample qualifier, sampled on Clk rising edge
Gray  input  W  Gray-coded input word
Clr  input  1  synchronous clear of state, counter and sticky error
Bin  output  W  registered binary decode of last accepted sample
Bin_valid  output  1  one-cycle pulse: Bin updated this cycle
Overflow  output  1  one-cycle pulse: accepted step 2^W-1 -> 0
Step_err  output  1  one-cycle pulse: illegal transition detected
Err_sticky  output  1  set by any Step_err, cleared only by Clr/reset
Wrap_cnt  output  WRAP_CNT_W  saturating count of Overflow events
State  output  2  FSM state: 00 IDLE, 01 LOCK, 10 ERR

Behaviour:
- One clock (Clk). Reset is asynchronous and active-low (Reset_n).
- Reset (Reset_n=0, asynchronous) forces all outputs to 0 and State to IDLE.
- Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0. Combinational decode; all outputs registered.
- Latency: a sample accepted at edge k shows on Bin, Bin_valid, Overflow and Step_err after edge k. Pulses last exactly one cycle.
- Valid=0: outputs hold, pulses deassert, no state change.
- Bin updates on every accepted sample, including erroneous ones. prev = the Bin register.
- IDLE: first Valid sample loads Bin, pulses Bin_valid, goes to LOCK. No step check, no Overflow.
- LOCK: for each Valid sample compute d = (new - prev) mod 2^W.
  - d==0: legal hold; Bin_valid pulses; no other effect.
  - d==1: legal step. If prev==2^W-1 and new==0: Overflow pulses and Wrap_cnt increments, saturating at 2^WRAP_CNT_W-1. Overflow still pulses when saturated.
  - Any other d: Step_err pulses, Err_sticky=1, go to ERR. No Overflow and no Wrap_cnt change.
- ERR: next Valid sample is a new reference (no check, no Overflow), Bin_valid pulses, go to LOCK. Err_sticky stays 1.
- Clr=1 (synchronous, priority over Valid): State=IDLE, Wrap_cnt=0, Err_sticky=0, all pulses 0. A simultaneous sample is discarded. Bin holds its value.
- Reset_n asserted mid-stream: immediate clear. After release, the first Valid sample is treated as in IDLE.

Optional Feature:
- Macro: GRAY_DEC_ZERO_RESYNC_EN.
- Defined: in LOCK, a sample decoding to 0 with prev not in {0, 2^W-1} is treated as an upstream counter reset. No Step_err, Err_sticky unchanged, no Overflow, no Wrap_cnt change. Bin=0, Bin_valid pulses, State stays LOCK.
- Not defined: that transition is an ordinary illegal step (Step_err, ERR).

Test Plan:
1. Reset, then Valid=1 with Gray 000,001,011,010,110,111,101,100,000 -> Bin 0..7,0. Overflow high only the cycle after the final 000. Wrap_cnt=1, Step_err never high, State LOCK.
2. Gray 011 held with Valid=1 for 3 cycles, then Valid=0 for 2 cycles -> Bin=2 throughout. Bin_valid high 3 cycles then low. No Step_err.
3. Gray 001 then 110 (1->4) -> Step_err pulse, Err_sticky=1, State=10. Then 111 (5) -> State=01, no error. Then 101 (6) -> legal, Err_sticky still 1.
4. Clr=1 together with Valid=1, Gray=001 after test 3 -> next cycle Wrap_cnt=0, Err_sticky=0, Bin_valid=0, State=00, Bin unchanged (6).
5. WRAP_CNT_W=2, drive 5 full 0..7 cycles -> Wrap_cnt 1,2,3,3,3. Overflow pulses 5 times.
6. Sequence 101 (6) then 000 -> with GRAY_DEC_ZERO_RESYNC_EN: Bin=0, no Step_err, Wrap_cnt unchanged. Without the macro: Step_err pulse, State=10. Also assert Reset_n=0 mid-sequence between edges -> all outputs 0 immediately.
